noc_local_injector: RTL and testbench

- Network-interface transmitter that feeds a switch's Local input port.
- Buffers flits pushed by the processing element (PE) and computes the first-hop XY route from the header flit.
- Drives the 3-bit request code and 8-bit flit bus into the switch. Holds each flit until the switch's grant accepts it.
- The PE-facing side is an ordinary FIFO write port; the switch-facing side is the switch's request/grant/data protocol.

---
 rtl/noc_pkg.sv | 44 ++++
 rtl/noc_sync_fifo.sv | 47 ++++
 rtl/noc_local_injector.sv | 132 +++++++++++++
 tb/tb_noc_local_injector.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: route codes, header layout, injector states and the XY route function.
package noc_pkg;

  localparam logic [2:0] RT_L    = 3'd0;
  localparam logic [2:0] RT_N    = 3'd1;
  localparam logic [2:0] RT_E    = 3'd2;
  localparam logic [2:0] RT_S    = 3'd3;
  localparam logic [2:0] RT_W    = 3'd4;
  localparam logic [2:0] RT_IDLE = 3'd7;

  localparam int FLIT_W  = 8;
  localparam int COORD_W = 4;

  // Header flit: dest_x in bits [7:4], dest_y in bits [3:0].
  typedef struct packed {
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } hdr_t;

  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] data;
  } flit_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_SEND,
    ST_DISCARD
  } inj_state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] xy_route(hdr_t hdr, logic [COORD_W-1:0] x_id,
                                          logic [COORD_W-1:0] y_id);
    logic [2:0] rt;
    if (hdr.dest_x > x_id)      rt = RT_E;
    else if (hdr.dest_x < x_id) rt = RT_W;
    else if (hdr.dest_y > y_id) rt = RT_N;
    else if (hdr.dest_y < y_id) rt = RT_S;
    else                        rt = RT_L;
    return rt;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead FIFO: dout is the head entry in the same cycle it is written; pop/push both honoured.
// Pushes while full are dropped; flush empties the FIFO on the next edge.
module noc_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_local_injector.sv
// Local-port injector: buffers whole PE packets, XY-routes the header, then streams flits on grant.
// Request appears two edges after the completing push; each flit is held until grant_in accepts it.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       full,
  output logic [7:0] flit_out,
  output logic [2:0] request_out,
  input  logic       grant_in,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_dest,
  output logic       err_oversize
);

  localparam int         CW    = $clog2(DEPTH) + 1;
  localparam logic [4:0] MAX_X = 5'(MESH_X);
  localparam logic [4:0] MAX_Y = 5'(MESH_Y);

  flit_entry_t fifo_din;
  flit_entry_t fifo_head;
  hdr_t        head_hdr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        push_last;
  logic        pop_last;
  logic [CW-1:0] pkt_cnt;
  inj_state_t  state;
  logic [2:0]  route_q;
  logic        dest_bad_q;

  assign fifo_din = {wr_last, wr_data};
  assign head_hdr = fifo_head.data;
  assign full     = fifo_full;

  // A full FIFO with no complete packet can never drain: the packet is longer than DEPTH.
  assign fifo_flush = fifo_full && (pkt_cnt == '0);
  assign fifo_pop   = !fifo_empty &&
                      (((state == ST_SEND) && grant_in) || (state == ST_DISCARD));
  assign push_last  = wr_en && wr_last && !fifo_full;
  assign pop_last   = fifo_pop && fifo_head.last;
  assign flit_out   = (state == ST_SEND) ? fifo_head.data : '0;

  noc_sync_fifo #(
    .WIDTH($bits(flit_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(fifo_flush),
    .push (wr_en),
    .din  (fifo_din),
    .pop  (fifo_pop),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || fifo_flush) begin
      pkt_cnt <= '0;
    end else if (push_last && !pop_last) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end else if (pop_last && !push_last) begin
      pkt_cnt <= pkt_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      request_out  <= RT_IDLE;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      err_dest     <= 1'b0;
      err_oversize <= 1'b0;
      route_q      <= RT_IDLE;
      dest_bad_q   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (fifo_flush) err_oversize <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pkt_cnt != '0) begin
            route_q    <= xy_route(head_hdr, 4'(X_ID), 4'(Y_ID));
            dest_bad_q <= ({1'b0, head_hdr.dest_x} >= MAX_X) ||
                          ({1'b0, head_hdr.dest_y} >= MAX_Y);
            state      <= ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          if (dest_bad_q) begin
            state <= ST_DISCARD;
          end else begin
            request_out <= route_q;
            busy        <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop_last) begin
            request_out <= RT_IDLE;
            busy        <= 1'b0;
            pkt_done    <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (pop_last) begin
            err_dest <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector at node (1,1) in a 4x4 mesh: directed vectors plus randomized packets.
module tb_noc_local_injector;

  localparam int         DEPTH     = 16;
  localparam int         X_ID      = 1;
  localparam int         Y_ID      = 1;
  localparam int         MESH_X    = 4;
  localparam int         MESH_Y    = 4;
  localparam int         NRAND     = 40;
  localparam logic [2:0] IDLE_CODE = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       full;
  logic [7:0] flit_out;
  logic [2:0] request_out;
  logic       grant_in;
  logic       busy;
  logic       pkt_done;
  logic       err_dest;
  logic       err_oversize;

  noc_local_injector #(
    .DEPTH(DEPTH), .X_ID(X_ID), .Y_ID(Y_ID), .MESH_X(MESH_X), .MESH_Y(MESH_Y)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full(full), .flit_out(flit_out), .request_out(request_out), .grant_in(grant_in),
    .busy(busy), .pkt_done(pkt_done), .err_dest(err_dest), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: packets the switch side should see, in order.
  logic [7:0] exp_flit_q [$];
  int         exp_len_q [$];
  logic [2:0] exp_route_q [$];

  int         rem = 0;
  logic [2:0] cur_route = IDLE_CODE;
  logic       done_due = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_flit = '0;
  logic [2:0] prev_req = IDLE_CODE;

  logic [7:0] pk [16];
  int         pk_len = 0;

  typedef struct {
    logic [7:0] hdr;
    logic [2:0] route;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference routing from the mesh rules; -1 means the packet must be discarded.
  function automatic int model_route(input logic [7:0] h);
    int hx, hy, dx, dy;
    hx = int'(h[7:4]);
    hy = int'(h[3:0]);
    if (hx >= MESH_X || hy >= MESH_Y) return -1;
    dx = hx - X_ID;
    dy = hy - Y_ID;
    if (dx > 0) return 2;
    if (dx < 0) return 4;
    if (dy > 0) return 1;
    if (dy < 0) return 3;
    return 0;
  endfunction

  task automatic monitor();
    if (prev_hold) begin
      check("hold_flit", 32'(flit_out), 32'(prev_flit));
      check("hold_req", 32'(request_out), 32'(prev_req));
    end
    if (pkt_done || done_due) check("pkt_done", 32'(pkt_done), 32'(done_due));
    done_due = 1'b0;
    if (request_out == IDLE_CODE) check("idle_flit_zero", 32'(flit_out), 32'd0);
    prev_hold = (request_out != IDLE_CODE) && !grant_in;
    prev_flit = flit_out;
    prev_req  = request_out;
    if (request_out != IDLE_CODE && grant_in) begin
      if (rem == 0) begin
        if (exp_len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request: got request %0d flit %0h, expected no request",
                   request_out, flit_out);
        end else begin
          rem       = exp_len_q.pop_front();
          cur_route = exp_route_q.pop_front();
          check("route", 32'(request_out), 32'(cur_route));
        end
      end else begin
        check("route_const", 32'(request_out), 32'(cur_route));
      end
      if (rem > 0) begin
        check("flit", 32'(flit_out), 32'(exp_flit_q.pop_front()));
        rem--;
        if (rem == 0) done_due = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [7:0] d, input logic l);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = l;
    step();
    wr_en   = 1'b0;
    wr_last = 1'b0;
    wr_data = '0;
  endtask

  task automatic expect_pk();
    int r;
    r = model_route(pk[0]);
    if (r >= 0) begin
      exp_len_q.push_back(pk_len);
      exp_route_q.push_back(3'(r));
      for (int i = 0; i < pk_len; i++) exp_flit_q.push_back(pk[i]);
    end
  endtask

  task automatic push_pk();
    expect_pk();
    for (int i = 0; i < pk_len; i++) push_flit(pk[i], i == pk_len - 1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (request_out == IDLE_CODE && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(request_out != IDLE_CODE), 32'd1);
  endtask

  task automatic drain_grant(input string name);
    int n = 0;
    grant_in = 1'b1;
    while (!pkt_done && n < 40) begin
      step();
      n++;
    end
    grant_in = 1'b0;
    check(name, 32'(pkt_done), 32'd1);
    check({name, "_req_idle"}, 32'(request_out), 32'(IDLE_CODE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t       vt [8];
    logic [8:0] stim_q [$];
    logic       bp [7];
    int         n_gen;
    int         guard;
    logic       bad;
    logic [3:0] hx, hy;

    vt[0] = '{8'h12, 3'd1};
    vt[1] = '{8'h10, 3'd3};
    vt[2] = '{8'h01, 3'd4};
    vt[3] = '{8'h11, 3'd0};
    vt[4] = '{8'h31, 3'd2};
    vt[5] = '{8'h13, 3'd1};
    vt[6] = '{8'h03, 3'd4};
    vt[7] = '{8'h33, 3'd2};
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; grant_in = 1'b0;
    repeat (3) step();
    check("rst_request", 32'(request_out), 32'(IDLE_CODE));
    check("rst_flit", 32'(flit_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_err_dest", 32'(err_dest), 32'd0);
    check("rst_err_oversize", 32'(err_oversize), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    step();

    // Header-only packets: route priority, loopback and two-edge request latency.
    for (int i = 0; i < 8; i++) begin
      pk[0] = vt[i].hdr;
      pk_len = 1;
      push_pk();
      check("lat_edge_k", 32'(request_out), 32'(IDLE_CODE));
      step();
      check("lat_edge_k1", 32'(request_out), 32'(IDLE_CODE));
      step();
      check("tbl_route", 32'(request_out), 32'(vt[i].route));
      check("tbl_flit", 32'(flit_out), 32'(vt[i].hdr));
      check("tbl_busy", 32'(busy), 32'd1);
      drain_grant("tbl_done");
    end
    step();

    // Two-flit packet eastward.
    pk[0] = 8'h31; pk[1] = 8'h20; pk_len = 2;
    push_pk();
    wait_req("two_wait");
    check("two_route", 32'(request_out), 32'd2);
    drain_grant("two_done");
    step();

    // Back-pressure: flits held on grant=0, done after the fourth accepted flit.
    pk[0] = 8'h31; pk[1] = 8'hC1; pk[2] = 8'hC2; pk[3] = 8'hC3; pk_len = 4;
    push_pk();
    wait_req("bp_wait");
    for (int i = 0; i < 7; i++) begin
      grant_in = bp[i];
      step();
      if (i < 6) check("bp_no_early_done", 32'(pkt_done), 32'd0);
    end
    grant_in = 1'b0;
    check("bp_done", 32'(pkt_done), 32'd1);
    check("bp_busy", 32'(busy), 32'd0);
    step();

    // Next packet written while the current one drains; push-last coincides with pop-last.
    pk[0] = 8'h12; pk[1] = 8'hB1; pk[2] = 8'hB2; pk[3] = 8'hB3; pk_len = 4;
    push_pk();
    wait_req("sim_wait");
    grant_in = 1'b1;
    step();
    pk[0] = 8'h01; pk[1] = 8'hE1; pk[2] = 8'hE2; pk_len = 3;
    expect_pk();
    push_flit(8'h01, 1'b0);
    push_flit(8'hE1, 1'b0);
    push_flit(8'hE2, 1'b1);
    grant_in = 1'b0;
    check("sim_done_a", 32'(pkt_done), 32'd1);
    check("sim_req_idle0", 32'(request_out), 32'(IDLE_CODE));
    step();
    check("sim_req_idle1", 32'(request_out), 32'(IDLE_CODE));
    step();
    check("sim_route_b", 32'(request_out), 32'd4);
    check("sim_flit_b", 32'(flit_out), 32'h01);
    drain_grant("sim_done_b");
    step();

    // Illegal destination: discarded silently, err_dest set, FIFO left clean.
    check("dest_err_before", 32'(err_dest), 32'd0);
    pk[0] = 8'h50; pk[1] = 8'hAA; pk[2] = 8'h55; pk_len = 3;
    push_pk();
    grant_in = 1'b1;
    repeat (10) step();
    grant_in = 1'b0;
    check("dest_err_after", 32'(err_dest), 32'd1);
    check("dest_busy", 32'(busy), 32'd0);
    pk[0] = 8'h11; pk_len = 1;
    push_pk();
    wait_req("dest_next_wait");
    check("dest_next_flit", 32'(flit_out), 32'h11);
    drain_grant("dest_next_done");
    step();

    // Randomized packets with random grant and concurrent writes.
    n_gen = 0;
    guard = 0;
    while ((n_gen < NRAND || stim_q.size() > 0 || exp_len_q.size() > 0 || rem > 0) &&
           guard < 20000) begin
      if (stim_q.size() == 0 && n_gen < NRAND) begin
        bad = (n_gen % 7) == 5;
        hx = (bad && (n_gen % 2) == 1) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        hy = (bad && (n_gen % 2) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        pk_len = int'($urandom_range(1, 8));
        pk[0] = {hx, hy};
        for (int i = 1; i < pk_len; i++) pk[i] = 8'($urandom);
        expect_pk();
        for (int i = 0; i < pk_len; i++) stim_q.push_back({i == pk_len - 1, pk[i]});
        n_gen++;
      end
      if (stim_q.size() > 0 && !full && $urandom_range(0, 3) != 0) begin
        wr_en = 1'b1;
        {wr_last, wr_data} = stim_q.pop_front();
      end else begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_data = 8'($urandom);
      end
      grant_in = ($urandom_range(0, 9) < 6);
      step();
      guard++;
    end
    wr_en = 1'b0; wr_last = 1'b0; grant_in = 1'b0;
    check("rand_drained", 32'(guard < 20000), 32'd1);
    repeat (12) step();
    check("rand_busy", 32'(busy), 32'd0);
    check("rand_req_idle", 32'(request_out), 32'(IDLE_CODE));
    check("rand_err_oversize", 32'(err_oversize), 32'd0);

    // Oversize: DEPTH+1 flits without last flush the FIFO.
    for (int i = 0; i < DEPTH; i++) push_flit(8'h40 + 8'(i), 1'b0);
    check("ovs_full", 32'(full), 32'd1);
    check("ovs_err_before", 32'(err_oversize), 32'd0);
    push_flit(8'h7F, 1'b0);
    check("ovs_err_after", 32'(err_oversize), 32'd1);
    check("ovs_full_after", 32'(full), 32'd0);
    check("ovs_req_idle", 32'(request_out), 32'(IDLE_CODE));
    pk[0] = 8'h21; pk_len = 1;
    push_pk();
    wait_req("ovs_next_wait");
    check("ovs_next_route", 32'(request_out), 32'd2);
    check("ovs_next_flit", 32'(flit_out), 32'h21);
    drain_grant("ovs_next_done");
    step();

    // Reset mid-packet drops everything buffered and in flight.
    pk[0] = 8'h31; pk[1] = 8'hD1; pk[2] = 8'hD2; pk[3] = 8'hD3; pk_len = 4;
    push_pk();
    wait_req("mid_wait");
    check("mid_route", 32'(request_out), 32'd2);
    grant_in = 1'b1;
    step();
    grant_in = 1'b0;
    rst = 1'b1;
    step();
    exp_flit_q.delete();
    exp_len_q.delete();
    exp_route_q.delete();
    rem = 0; done_due = 1'b0; prev_hold = 1'b0;
    check("mid_rst_request", 32'(request_out), 32'(IDLE_CODE));
    check("mid_rst_flit", 32'(flit_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_err_dest", 32'(err_dest), 32'd0);
    check("mid_rst_err_oversize", 32'(err_oversize), 32'd0);
    rst = 1'b0;
    step();
    pk[0] = 8'h10; pk_len = 1;
    push_pk();
    wait_req("post_rst_wait");
    check("post_rst_route", 32'(request_out), 32'd3);
    check("post_rst_flit", 32'(flit_out), 32'h10);
    drain_grant("post_rst_done");
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
